// File: rtl/audio_pkg.sv
// Shared audio-path types: envelope state encoding, full-scale level and
// the signed sample type used between synth, envelope and codec driver.
package audio_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam logic [15:0] ENV_MAX = 16'hFFFF;

  typedef logic signed [15:0] sample_t;
endpackage

// File: rtl/adsr_scaler.sv
// Registered amplitude scaler: on a tick, sample_out <= (sample_in * level) >>> 16
// (signed sample times unsigned level, floor), with out_valid pulsing the cycle after.
// Ports:
//   Clk, Reset  clock, synchronous active-high reset
//   tick        sample strobe
//   sample_in   signed input sample
//   level       unsigned gain, 0..FFFF (caller supplies the pre-update level)
//   sample_out  signed scaled sample
//   out_valid   one-Clk pulse when sample_out updates
module adsr_scaler
  import audio_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        tick,
  input  sample_t     sample_in,
  input  logic [15:0] level,
  output sample_t     sample_out,
  output logic        out_valid
);
  logic signed [32:0] a, b, prod;

  // Level is zero-extended so it stays non-negative in the signed product.
  assign a    = {{17{sample_in[15]}}, sample_in};
  assign b    = {17'b0, level};
  assign prod = a * b;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sample_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= tick;
      if (tick) sample_out <= 16'(prod >>> 16);
    end
  end
endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope. Each sample_tick advances the state machine and level
// and emits sample_in scaled by the level held before that tick.
// Ports:
//   Clk, Reset   clock, synchronous active-high reset (aborts a note, no tail)
//   sample_tick  one-Clk strobe per audio sample
//   gate         note held / released, sampled only on sample_tick
//   sample_in    signed sample from the wavetable synth
//   sample_out   signed scaled sample, out_valid pulses 1 Clk after the tick
//   env_level    current envelope level
//   env_state    current state (env_state_t)
//   active       high whenever env_state != IDLE
module adsr_envelope
  import audio_pkg::*;
#(
  parameter logic [15:0] ATTACK_STEP   = 16'h0100,
  parameter logic [15:0] DECAY_STEP    = 16'h0040,
  parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
  parameter logic [15:0] RELEASE_STEP  = 16'h0020
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        sample_tick,
  input  logic        gate,
  input  logic [15:0] sample_in,
  output logic [15:0] sample_out,
  output logic        out_valid,
  output logic [15:0] env_level,
  output logic [2:0]  env_state,
  output logic        active
);
  env_state_t  state, state_nx;
  logic [15:0] level, level_nx;
  logic [16:0] att_sum, dec_diff, rel_diff;

  // 17-bit arithmetic so overflow / underflow is visible in bit 16 and clamped.
  assign att_sum  = {1'b0, level} + {1'b0, ATTACK_STEP};
  assign dec_diff = {1'b0, level} - {1'b0, DECAY_STEP};
  assign rel_diff = {1'b0, level} - {1'b0, RELEASE_STEP};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      level <= '0;
    end else if (sample_tick) begin
      state <= state_nx;
      level <= level_nx;
    end
  end

  // A gate-driven transition never steps the level on that tick.
  always_comb begin
    state_nx = state;
    level_nx = level;
    unique case (state)
      IDLE: begin
        level_nx = '0;
        if (gate) state_nx = ATTACK;
      end
      ATTACK: begin
        if (!gate) state_nx = RELEASE;
        else if (att_sum >= {1'b0, ENV_MAX}) begin
          level_nx = ENV_MAX;
          state_nx = DECAY;
        end else level_nx = att_sum[15:0];
      end
      DECAY: begin
        if (!gate) state_nx = RELEASE;
        else if (dec_diff[16] || dec_diff[15:0] <= SUSTAIN_LEVEL) begin
          level_nx = SUSTAIN_LEVEL;
          state_nx = SUSTAIN;
        end else level_nx = dec_diff[15:0];
      end
      SUSTAIN: begin
        if (!gate) state_nx = RELEASE;
      end
      RELEASE: begin
        if (gate) state_nx = ATTACK;
        else if (rel_diff[16] || rel_diff[15:0] == 16'h0) begin
          level_nx = '0;
          state_nx = IDLE;
        end else level_nx = rel_diff[15:0];
      end
      default: begin
        state_nx = IDLE;
        level_nx = '0;
      end
    endcase
  end

  assign env_level = level;
  assign env_state = state;
  assign active    = (state != IDLE);

  adsr_scaler u_scaler (
    .Clk        (Clk),
    .Reset      (Reset),
    .tick       (sample_tick),
    .sample_in  (sample_in),
    .level      (level),
    .sample_out (sample_out),
    .out_valid  (out_valid)
  );
endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with hand-computed level / state / sample values.
module tb_adsr_envelope;
  import audio_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        gate = 1'b0;
  logic [15:0] sample_in = '0;
  logic [15:0] sample_out;
  logic        out_valid;
  logic [15:0] env_level;
  logic [2:0]  env_state;
  logic        active;

  int n_tests = 0;
  int n_fail  = 0;

  adsr_envelope #(
    .ATTACK_STEP   (16'h4000),
    .DECAY_STEP    (16'h1000),
    .SUSTAIN_LEVEL (16'hC000),
    .RELEASE_STEP  (16'h4000)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .sample_tick (sample_tick),
    .gate        (gate),
    .sample_in   (sample_in),
    .sample_out  (sample_out),
    .out_valid   (out_valid),
    .env_level   (env_level),
    .env_state   (env_state),
    .active      (active)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled on negedges, away from the active edge.
  task automatic chk_env(input string tag, input logic [15:0] lvl, input env_state_t st,
                         input logic [15:0] so);
    chk({tag, ".level"},  32'(env_level),  32'(lvl));
    chk({tag, ".state"},  32'(env_state),  32'(st));
    chk({tag, ".active"}, 32'(active),     32'(st != IDLE));
    chk({tag, ".sample"}, 32'(sample_out), 32'(so));
  endtask

  // One tick per 16 Clk. out_valid must be high exactly one Clk after the tick edge.
  task automatic do_tick(input logic g, input logic [15:0] s);
    @(negedge Clk);
    gate = g; sample_in = s; sample_tick = 1'b1;
    @(negedge Clk);
    sample_tick = 1'b0;
    chk("out_valid_hi", 32'(out_valid), 32'd1);
  endtask

  task automatic gap();
    @(negedge Clk);
    chk("out_valid_lo", 32'(out_valid), 32'd0);
    repeat (13) @(negedge Clk);
  endtask

  initial begin
    // 1: reset, then idle ticks
    repeat (3) @(negedge Clk);
    chk_env("reset", 16'h0, IDLE, 16'h0);
    chk("reset.valid", 32'(out_valid), 32'd0);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_tick(1'b0, 16'h7FFF);
      chk_env("idle", 16'h0, IDLE, 16'h0);
      gap();
    end

    // 2/3: attack with scaling checks on pre-update levels
    do_tick(1'b1, 16'h1234); chk_env("att1", 16'h0000, ATTACK, 16'h0000); gap();
    do_tick(1'b1, 16'h0000); chk_env("att2", 16'h4000, ATTACK, 16'h0000); gap();
    do_tick(1'b1, 16'h0000); chk_env("att3", 16'h8000, ATTACK, 16'h0000); gap();
    do_tick(1'b1, 16'h7FFF); chk_env("att4", 16'hC000, ATTACK, 16'h3FFF); gap();
    do_tick(1'b1, 16'h4000); chk_env("att5", 16'hFFFF, DECAY,  16'h3000); gap();
    do_tick(1'b1, 16'h8000); chk_env("dec1", 16'hEFFF, DECAY,  16'h8000); gap();
    do_tick(1'b1, 16'hFFFF); chk_env("dec2", 16'hDFFF, DECAY,  16'hFFFF); gap();
    do_tick(1'b1, 16'h0000); chk_env("dec3", 16'hCFFF, DECAY,  16'h0000); gap();
    do_tick(1'b1, 16'h0000); chk_env("dec4", 16'hC000, SUSTAIN, 16'h0000); gap();
    for (int i = 0; i < 10; i++) begin
      // Gate dropped between ticks and restored before the next one is ignored.
      if (i == 4) begin
        @(negedge Clk); gate = 1'b0;
        repeat (3) @(negedge Clk); gate = 1'b1;
      end
      do_tick(1'b1, 16'h0000); chk_env("sus", 16'hC000, SUSTAIN, 16'h0000); gap();
    end

    // 4: release to idle
    do_tick(1'b0, 16'h0000); chk_env("rel0", 16'hC000, RELEASE, 16'h0000); gap();
    do_tick(1'b0, 16'h0000); chk_env("rel1", 16'h8000, RELEASE, 16'h0000); gap();
    do_tick(1'b0, 16'h0000); chk_env("rel2", 16'h4000, RELEASE, 16'h0000); gap();
    do_tick(1'b0, 16'h0000); chk_env("rel3", 16'h0000, IDLE,    16'h0000); gap();

    // 5: retrigger from 8000 in release
    do_tick(1'b1, 16'h0000); chk_env("rt_a",  16'h0000, ATTACK,  16'h0000); gap();
    do_tick(1'b1, 16'h0000); chk_env("rt_b",  16'h4000, ATTACK,  16'h0000); gap();
    do_tick(1'b1, 16'h0000); chk_env("rt_c",  16'h8000, ATTACK,  16'h0000); gap();
    do_tick(1'b0, 16'h0000); chk_env("rt_rel", 16'h8000, RELEASE, 16'h0000); gap();
    do_tick(1'b1, 16'h0000); chk_env("rt_att", 16'h8000, ATTACK, 16'h0000); gap();
    do_tick(1'b1, 16'h0000); chk_env("rt_s1", 16'hC000, ATTACK,  16'h0000); gap();
    do_tick(1'b1, 16'h0000); chk_env("rt_s2", 16'hFFFF, DECAY,   16'h0000); gap();
    do_tick(1'b1, 16'h7FFF); chk_env("rt_d1", 16'hEFFF, DECAY,   16'h7FFE); gap();

    // 6: reset coincident with a tick mid-decay
    @(negedge Clk);
    Reset = 1'b1; sample_tick = 1'b1; gate = 1'b1; sample_in = 16'h7FFF;
    @(negedge Clk);
    Reset = 1'b0; sample_tick = 1'b0;
    chk_env("rst_mid", 16'h0000, IDLE, 16'h0000);
    chk("rst_mid.valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
